// File: rtl/music_sequencer_pkg.sv
// music_pkg: track encodings, silence word, shared note words and sequencer states
package music_pkg;
    localparam logic [1:0] TRK_NONE = 2'd0;
    localparam logic [1:0] TRK_NORM = 2'd1;
    localparam logic [1:0] TRK_BOSS = 2'd2;
    localparam logic [1:0] TRK_SFX  = 2'd3;
    localparam logic [31:0] SILENCE = 32'd20000;
    localparam logic [31:0] NOTE_C4 = 32'd262;
    localparam logic [31:0] NOTE_E4 = 32'd330;
    localparam logic [31:0] NOTE_G4 = 32'd392;
    localparam logic [31:0] NOTE_C5 = 32'd523;
    typedef enum logic [1:0] {ST_IDLE, ST_BGM, ST_SFX} state_t;
endpackage

// File: rtl/music_sequencer_if.sv
// music_sequencer_if: game-FSM / tone-ROM side bundle of the music sequencer
interface music_sequencer_if #(parameter int BEAT_W = 10);
    logic [1:0] bgm_sel;
    logic sfx_req;
    logic pause;
    logic [31:0] tone_in;
    logic [BEAT_W-1:0] ibeat_num;
    logic [1:0] track;
    logic [31:0] tone_out;
    logic sfx_busy;
    logic playing;
    modport master (output bgm_sel, sfx_req, pause, tone_in, input ibeat_num, track, tone_out, sfx_busy, playing);
    modport slave (input bgm_sel, sfx_req, pause, tone_in, output ibeat_num, track, tone_out, sfx_busy, playing);
endinterface

// File: rtl/music_sequencer_beat_divider.sv
// beat_divider: one-cycle tick every N enabled cycles; holds while disabled, sync clear
module beat_divider #(parameter int N = 12500000) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int W = (N > 1) ? $clog2(N) : 1;
    logic [W-1:0] cnt;
    assign tick = en && cnt == W'(N - 1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else if (clr || tick) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/music_sequencer.sv
// music_sequencer: 1/4-beat sequencer arbitrating looping BGM against a one-shot SFX jingle
// MUSIC_RESUME_EN: when defined, BGM resumes at the interrupted beat after the jingle
module music_sequencer #(
    parameter int CLK_HZ = 100000000,
    parameter int BEAT_HZ = 8,
    parameter int BEAT_W = 10,
    parameter int LEN_NORM = 352,
    parameter int LEN_BOSS = 352,
    parameter int LEN_SFX = 32,
    parameter logic [31:0] SILENCE = music_pkg::SILENCE
) (
    input logic clk,
    input logic rst_n,
    music_sequencer_if.slave bus
);
    import music_pkg::*;
    state_t state, state_n;
    logic [1:0] bgm, bgm_n, sel;
    logic [BEAT_W-1:0] beat, beat_n, last, resume;
    logic clr, tick, chg;
`ifdef MUSIC_RESUME_EN
    logic [BEAT_W-1:0] saved, saved_n;
    assign resume = saved;
`else
    assign resume = '0;
`endif
    assign sel = bus.bgm_sel == TRK_SFX ? TRK_NONE : bus.bgm_sel;
    assign chg = sel != bgm;
    assign last = bgm == TRK_BOSS ? BEAT_W'(LEN_BOSS - 1) : BEAT_W'(LEN_NORM - 1);
    assign bus.ibeat_num = beat;
    beat_divider #(.N(CLK_HZ / BEAT_HZ)) u_div (
        .clk(clk),
        .rst_n(rst_n),
        .en(state != ST_IDLE && !bus.pause),
        .clr(clr),
        .tick(tick)
    );
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= ST_IDLE;
            beat <= '0;
            bgm <= TRK_NONE;
`ifdef MUSIC_RESUME_EN
            saved <= '0;
`endif
            bus.tone_out <= SILENCE;
            bus.playing <= 1'b0;
        end else begin
            state <= state_n;
            beat <= beat_n;
            bgm <= bgm_n;
`ifdef MUSIC_RESUME_EN
            saved <= saved_n;
`endif
            bus.tone_out <= bus.playing && bus.track != TRK_NONE ? bus.tone_in : SILENCE;
            bus.playing <= state != ST_IDLE && !bus.pause;
        end
    // sfx_req outranks a bgm change; a change seen during SFX only retargets the return
    always_comb begin
        state_n = state;
        beat_n = beat;
        bgm_n = bgm;
        clr = 1'b0;
`ifdef MUSIC_RESUME_EN
        saved_n = saved;
`endif
        if (bus.sfx_req) begin
            state_n = ST_SFX;
            beat_n = '0;
            bgm_n = sel;
            clr = 1'b1;
`ifdef MUSIC_RESUME_EN
            saved_n = chg ? '0 : state == ST_SFX ? saved : beat;
`endif
        end else if (chg) begin
            bgm_n = sel;
`ifdef MUSIC_RESUME_EN
            saved_n = '0;
`endif
            if (state != ST_SFX) begin
                state_n = sel == TRK_NONE ? ST_IDLE : ST_BGM;
                beat_n = '0;
                clr = 1'b1;
            end
        end else if (state == ST_IDLE) state_n = bgm == TRK_NONE ? ST_IDLE : ST_BGM;
        else if (tick && state == ST_BGM) beat_n = beat == last ? '0 : beat + 1'b1;
        else if (tick && beat == BEAT_W'(LEN_SFX - 1)) begin
            state_n = bgm == TRK_NONE ? ST_IDLE : ST_BGM;
            beat_n = resume;
            clr = 1'b1;
        end else if (tick) beat_n = beat + 1'b1;
    end
    always_comb begin
        bus.track = state == ST_IDLE ? TRK_NONE : state == ST_SFX ? TRK_SFX : bgm;
        bus.sfx_busy = state == ST_SFX;
    end
endmodule

// File: tb/tb_music_sequencer.sv
// tb_music_sequencer: directed stimulus with a step scoreboard on track/ibeat_num changes
module tb_music_sequencer;
    typedef struct {logic [1:0] trk; int beat; logic busy; int gap;} exp_t;
    localparam logic [31:0] SIL = 32'd20000;
`ifdef MUSIC_RESUME_EN
    localparam int RB1 = 5;
    localparam int RB2 = 7;
`else
    localparam int RB1 = 0;
    localparam int RB2 = 0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int tests = 0;
    int errors = 0;
    int cyc = 0;
    int last = 0;
    int p_beat = 0;
    logic [1:0] p_trk = 2'd0;
    exp_t q[$];
    exp_t e;
    music_sequencer_if #(.BEAT_W(10)) bus();
    music_sequencer #(.CLK_HZ(16), .BEAT_HZ(2), .BEAT_W(10), .LEN_NORM(12), .LEN_BOSS(12), .LEN_SFX(4)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );
    always #5 clk = ~clk;
    always_comb bus.tone_in = 32'd1000 + 32'(bus.track) * 32'd100 + 32'(bus.ibeat_num);
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    task automatic push(input logic [1:0] t, input int b, input logic busy, input int g);
        q.push_back('{t, b, busy, g});
    endtask
    task automatic push_run(input logic [1:0] t, input int from, input int to);
        int b = from;
        push(t, b, 1'b0, 8);
        while (b != to) begin
            b = (b + 1) % 12;
            push(t, b, 1'b0, 8);
        end
    endtask
    task automatic wait_for(input logic [1:0] t, input int b, input string nm);
        int n = 0;
        while ((bus.track != t || int'(bus.ibeat_num) != b) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            tests++;
            errors++;
            $display("FAIL timeout_%s: got track %0d beat %0d", nm, bus.track, bus.ibeat_num);
        end
    endtask
    task automatic wait_drain(input string nm);
        int n = 0;
        while (q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            tests++;
            errors++;
            $display("FAIL drain_%s: %0d steps still expected", nm, q.size());
        end
    endtask
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            p_trk = 2'd0;
            p_beat = 0;
        end else if (bus.track != p_trk || int'(bus.ibeat_num) != p_beat) begin
            if (q.size() == 0) begin
                tests++;
                errors++;
                $display("FAIL unexpected_step: got track %0d beat %0d", bus.track, bus.ibeat_num);
            end else begin
                e = q.pop_front();
                chk("step_track", 32'(bus.track), 32'(e.trk));
                chk("step_beat", 32'(bus.ibeat_num), e.beat);
                chk("step_busy", 32'(bus.sfx_busy), 32'(e.busy));
                if (e.gap != 0) chk("step_gap", cyc - last, e.gap);
            end
            p_trk = bus.track;
            p_beat = int'(bus.ibeat_num);
            last = cyc;
        end
    end
    initial begin
        int bad;
        bus.bgm_sel = 2'd0;
        bus.sfx_req = 1'b0;
        bus.pause = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_track", 32'(bus.track), 0);
        chk("rst_tone", bus.tone_out, SIL);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (i == 50) bus.bgm_sel = 2'd3;
            @(negedge clk);
            if (bus.track != 2'd0 || bus.ibeat_num != 10'd0 || bus.tone_out != SIL || bus.playing || bus.sfx_busy) bad++;
        end
        chk("idle_hold", bad, 0);
        push(2'd1, 0, 1'b0, 0);
        push_run(2'd1, 1, 11);
        push_run(2'd1, 0, 5);
        bus.bgm_sel = 2'd1;
        wait_for(2'd1, 11, "norm11");
        wait_for(2'd1, 5, "norm5");
        repeat (2) @(negedge clk);
        chk("bgm_tone", bus.tone_out, 32'd1105);
        chk("bgm_playing", 32'(bus.playing), 1);
        push(2'd3, 0, 1'b1, 0);
        push(2'd3, 1, 1'b1, 8);
        push(2'd3, 2, 1'b1, 8);
        push(2'd3, 3, 1'b1, 8);
        push(2'd1, RB1, 1'b0, 8);
        push_run(2'd1, RB1 + 1, 7);
        bus.sfx_req = 1'b1;
        @(negedge clk);
        bus.sfx_req = 1'b0;
        wait_for(2'd1, 7, "after_sfx");
        push(2'd3, 0, 1'b1, 0);
        push(2'd3, 1, 1'b1, 8);
        push(2'd3, 2, 1'b1, 8);
        bus.sfx_req = 1'b1;
        @(negedge clk);
        bus.sfx_req = 1'b0;
        wait_for(2'd3, 2, "sfx2");
        push(2'd3, 0, 1'b1, 0);
        push(2'd3, 1, 1'b1, 8);
        push(2'd3, 2, 1'b1, 8);
        push(2'd3, 3, 1'b1, 8);
        push(2'd1, RB2, 1'b0, 8);
        if (RB2 != 7) push_run(2'd1, RB2 + 1, 7);
        bus.sfx_req = 1'b1;
        @(negedge clk);
        bus.sfx_req = 1'b0;
        wait_for(2'd1, 7, "after_retrig");
        wait_drain("retrig");
        push(2'd2, 0, 1'b0, 0);
        push(2'd2, 1, 1'b0, 8);
        push(2'd2, 2, 1'b0, 8);
        bus.bgm_sel = 2'd2;
        wait_for(2'd2, 2, "boss2");
        push(2'd3, 0, 1'b1, 0);
        push(2'd3, 1, 1'b1, 8);
        push(2'd3, 2, 1'b1, 8);
        push(2'd3, 3, 1'b1, 8);
        push(2'd1, 0, 1'b0, 8);
        push(2'd1, 1, 1'b0, 8);
        bus.bgm_sel = 2'd1;
        bus.sfx_req = 1'b1;
        @(negedge clk);
        bus.sfx_req = 1'b0;
        wait_for(2'd1, 1, "norm_after_combo");
        wait_drain("combo");
        repeat (2) @(negedge clk);
        push(2'd1, 2, 1'b0, 48);
        push(2'd1, 3, 1'b0, 8);
        bus.pause = 1'b1;
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i >= 1 && (bus.playing || bus.tone_out != SIL || bus.ibeat_num != 10'd1)) bad++;
        end
        chk("pause_hold", bad, 0);
        bus.pause = 1'b0;
        wait_drain("pause");
        repeat (2) @(negedge clk);
        chk("resume_tone", bus.tone_out, 32'd1103);
        chk("resume_playing", 32'(bus.playing), 1);
        push(2'd3, 0, 1'b1, 0);
        push(2'd3, 1, 1'b1, 8);
        bus.sfx_req = 1'b1;
        @(negedge clk);
        bus.sfx_req = 1'b0;
        wait_for(2'd3, 1, "sfx_rst");
        repeat (2) @(negedge clk);
        chk("sfx_tone", bus.tone_out, 32'd1301);
        bus.bgm_sel = 2'd0;
        rst_n = 1'b0;
        #1;
        chk("arst_track", 32'(bus.track), 0);
        chk("arst_beat", 32'(bus.ibeat_num), 0);
        chk("arst_busy", 32'(bus.sfx_busy), 0);
        chk("arst_playing", 32'(bus.playing), 0);
        chk("arst_tone", bus.tone_out, SIL);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("post_rst_track", 32'(bus.track), 0);
        chk("queue_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
